gbn_rx_check: RTL

GBN_RX_CHECK -- requirements
Module: gbn_rx_check

---
 rtl/gbn_rx_check.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gbn_rx_check.sv
`default_nettype none
// ============================================================================
//  Module      : gbn_rx_check
//  Description : Go-Back-N receive checker. Consumes UDP header + payload,
//                strips the leading GBN beat, forwards in-order DATA packets
//                (header length reduced by 8), drops duplicates/gaps/control
//                packets and raises cumulative ACK / single NACK requests via
//                a one-entry response register.
//  Options     : GBN_RX_STATS_EN - when defined, stat_accept/stat_drop/
//                stat_nack are saturating counters; otherwise tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module gbn_rx_check #(
  parameter logic [31:0] INIT_SEQ  = 32'd1,
  parameter int          HDR_WIDTH = 112
) (
  input  logic                 aclk,
  input  logic                 aresetn,

  input  logic [HDR_WIDTH-1:0] s_udp_hdr_data,
  input  logic                 s_udp_hdr_valid,
  output logic                 s_udp_hdr_ready,

  input  logic [63:0]          s_udp_payload_axis_tdata,
  input  logic [7:0]           s_udp_payload_axis_tkeep,
  input  logic                 s_udp_payload_axis_tvalid,
  output logic                 s_udp_payload_axis_tready,
  input  logic                 s_udp_payload_axis_tlast,
  input  logic                 s_udp_payload_axis_tuser,

  output logic [HDR_WIDTH-1:0] m_usr_hdr_data,
  output logic                 m_usr_hdr_valid,
  input  logic                 m_usr_hdr_ready,

  output logic [63:0]          m_usr_payload_axis_tdata,
  output logic [7:0]           m_usr_payload_axis_tkeep,
  output logic                 m_usr_payload_axis_tvalid,
  input  logic                 m_usr_payload_axis_tready,
  output logic                 m_usr_payload_axis_tlast,
  output logic                 m_usr_payload_axis_tuser,

  output logic [39:0]          m_ack_data,
  output logic                 m_ack_valid,
  input  logic                 m_ack_ready,

  output logic [31:0]          expected_seq,
  output logic [31:0]          stat_accept,
  output logic [31:0]          stat_drop,
  output logic [31:0]          stat_nack
);

  localparam logic [7:0] TYPE_ACK  = 8'd1;
  localparam logic [7:0] TYPE_NACK = 8'd2;
  localparam logic [7:0] TYPE_DATA = 8'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GBN     = 3'd1,
    ST_HDR_OUT = 3'd2,
    ST_PASS    = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  state_t      state;
  logic        hdr_ready_q;   // header intake enable (IDLE only)
  logic        rx_ready_q;    // payload sink enable in GBN / DROP
  logic        usr_hdr_valid_q;
  logic        nack_sent;

  // Payload handshake and pass-through steering
  logic        in_pass;
  logic        hdr_fire;
  logic        pay_fire;

  assign in_pass                   = (state == ST_PASS);
  assign s_udp_hdr_ready           = hdr_ready_q;
  assign s_udp_payload_axis_tready = in_pass ? m_usr_payload_axis_tready : rx_ready_q;
  assign hdr_fire                  = s_udp_hdr_valid & hdr_ready_q;
  assign pay_fire                  = s_udp_payload_axis_tvalid & s_udp_payload_axis_tready;

  assign m_usr_hdr_valid           = usr_hdr_valid_q;
  assign m_usr_payload_axis_tvalid = in_pass & s_udp_payload_axis_tvalid;
  assign m_usr_payload_axis_tdata  = s_udp_payload_axis_tdata;
  assign m_usr_payload_axis_tkeep  = s_udp_payload_axis_tkeep;
  assign m_usr_payload_axis_tlast  = s_udp_payload_axis_tlast;
  assign m_usr_payload_axis_tuser  = s_udp_payload_axis_tuser;

  // GBN beat decode; the sign of (seq - expected) orders sequence numbers
  // across the 2^32 wrap.
  logic        gbn_beat;
  logic [7:0]  beat_type;
  logic [31:0] beat_seq;
  logic [31:0] seq_diff;
  logic        beat_is_data;
  logic        seq_match;
  logic        seq_behind;
  logic        seq_ahead;

  assign gbn_beat     = (state == ST_GBN) & pay_fire;
  assign beat_type    = s_udp_payload_axis_tdata[7:0];
  assign beat_seq     = s_udp_payload_axis_tdata[39:8];
  assign seq_diff     = beat_seq - expected_seq;
  assign beat_is_data = (beat_type == TYPE_DATA);
  assign seq_match    = (seq_diff == 32'd0);
  assign seq_behind   = seq_diff[31];
  assign seq_ahead    = ~seq_diff[31] & ~seq_match;

  // Classified events; a GBN beat carrying tlast never produces a response.
  logic        data_beat;
  logic        ev_inorder;
  logic        ev_dup;
  logic        ev_nack;
  logic        ev_accept;

  assign data_beat  = gbn_beat & ~s_udp_payload_axis_tlast & beat_is_data;
  assign ev_inorder = data_beat & seq_match;
  assign ev_dup     = data_beat & seq_behind;
  assign ev_nack    = data_beat & seq_ahead & ~nack_sent;
  assign ev_accept  = in_pass & pay_fire & s_udp_payload_axis_tlast
                      & ~s_udp_payload_axis_tuser;

  // Response request: at most one source can fire in any cycle.
  logic        ack_req;
  logic [39:0] ack_req_data;

  assign ack_req = ev_accept | ev_dup | ev_nack;

  always_comb begin
    ack_req_data = {expected_seq, TYPE_ACK};
    if (ev_nack) begin
      ack_req_data = {expected_seq, TYPE_NACK};
    end else if (ev_dup) begin
      ack_req_data = {expected_seq - 32'd1, TYPE_ACK};
    end
  end

  // Output header: length field reduced by the 8-byte GBN beat.
  logic [HDR_WIDTH-1:0] hdr_adj;
  assign hdr_adj = {s_udp_hdr_data[HDR_WIDTH-1 -: 16] - 16'd8,
                    s_udp_hdr_data[HDR_WIDTH-17:0]};

  // Packet sequencing FSM with registered handshake outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= ST_IDLE;
      hdr_ready_q     <= 1'b0;
      rx_ready_q      <= 1'b0;
      usr_hdr_valid_q <= 1'b0;
      m_usr_hdr_data  <= '0;
      expected_seq    <= INIT_SEQ;
      nack_sent       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_fire) begin
            m_usr_hdr_data <= hdr_adj;
            hdr_ready_q    <= 1'b0;
            rx_ready_q     <= 1'b1;
            state          <= ST_GBN;
          end else begin
            hdr_ready_q    <= 1'b1;
          end
        end
        ST_GBN: begin
          if (gbn_beat) begin
            if (s_udp_payload_axis_tlast) begin
              rx_ready_q  <= 1'b0;
              hdr_ready_q <= 1'b1;
              state       <= ST_IDLE;
            end else if (ev_inorder) begin
              rx_ready_q      <= 1'b0;
              usr_hdr_valid_q <= 1'b1;
              state           <= ST_HDR_OUT;
            end else begin
              state <= ST_DROP;
            end
            if (ev_nack) begin
              nack_sent <= 1'b1;
            end
          end
        end
        ST_HDR_OUT: begin
          if (m_usr_hdr_ready) begin
            usr_hdr_valid_q <= 1'b0;
            state           <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (pay_fire && s_udp_payload_axis_tlast) begin
            hdr_ready_q <= 1'b1;
            state       <= ST_IDLE;
            if (!s_udp_payload_axis_tuser) begin
              expected_seq <= expected_seq + 32'd1;
              nack_sent    <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (pay_fire && s_udp_payload_axis_tlast) begin
            rx_ready_q  <= 1'b0;
            hdr_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rx_ready_q      <= 1'b0;
          usr_hdr_valid_q <= 1'b0;
          hdr_ready_q     <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

  // Single-entry response register; a newer request replaces a pending one
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_ack_valid <= 1'b0;
      m_ack_data  <= '0;
    end else if (ack_req) begin
      m_ack_valid <= 1'b1;
      m_ack_data  <= ack_req_data;
    end else if (m_ack_ready) begin
      m_ack_valid <= 1'b0;
    end
  end

`ifdef GBN_RX_STATS_EN
  // Dropped packet: terminated from DROP, or a GBN beat that also ends it
  logic ev_drop;
  assign ev_drop = ((state == ST_DROP) & pay_fire & s_udp_payload_axis_tlast)
                   | (gbn_beat & s_udp_payload_axis_tlast);

  // Saturating statistics counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_accept <= '0;
      stat_drop   <= '0;
      stat_nack   <= '0;
    end else begin
      if (ev_accept && (stat_accept != 32'hFFFF_FFFF)) begin
        stat_accept <= stat_accept + 32'd1;
      end
      if (ev_drop && (stat_drop != 32'hFFFF_FFFF)) begin
        stat_drop <= stat_drop + 32'd1;
      end
      if (ev_nack && (stat_nack != 32'hFFFF_FFFF)) begin
        stat_nack <= stat_nack + 32'd1;
      end
    end
  end
`else
  assign stat_accept = 32'd0;
  assign stat_drop   = 32'd0;
  assign stat_nack   = 32'd0;
`endif

endmodule
`default_nettype wire
